// File: rtl/cpu_pkg.sv
// Shared types and encodings for the 8-bit accumulator CPU control unit.
package cpu_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned SEL_W    = 2;
  localparam int unsigned SRC_W    = 3;

  typedef enum logic [2:0] {
    ST_RESET   = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_OPERAND = 3'd3,
    ST_EXEC    = 3'd4,
    ST_JMP_LO  = 3'd5,
    ST_JMP_HI  = 3'd6,
    ST_HALT    = 3'd7
  } state_e;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_INC = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_DEC = 4'd6;

  localparam logic [SEL_W-1:0] ASEL_A    = 2'b00;
  localparam logic [SEL_W-1:0] ASEL_X    = 2'b01;
  localparam logic [SEL_W-1:0] ASEL_Y    = 2'b10;
  localparam logic [SEL_W-1:0] ASEL_ZERO = 2'b11;

  localparam logic [SEL_W-1:0] BSEL_MEM = 2'b00;
  localparam logic [SEL_W-1:0] BSEL_A   = 2'b01;
  localparam logic [SEL_W-1:0] BSEL_X   = 2'b10;
  localparam logic [SEL_W-1:0] BSEL_Y   = 2'b11;

  localparam logic [SRC_W-1:0] SRC_ALU = 3'b000;
  localparam logic [SRC_W-1:0] SRC_MEM = 3'b001;
  localparam logic [SRC_W-1:0] SRC_A   = 3'b010;
  localparam logic [SRC_W-1:0] SRC_X   = 3'b011;
  localparam logic [SRC_W-1:0] SRC_Y   = 3'b100;
  localparam logic [SRC_W-1:0] SRC_SP  = 3'b101;

  localparam logic [DATA_W-1:0] OP_LDA_IMM = 8'hA9;
  localparam logic [DATA_W-1:0] OP_LDX_IMM = 8'hA2;
  localparam logic [DATA_W-1:0] OP_LDY_IMM = 8'hA0;
  localparam logic [DATA_W-1:0] OP_ADC_IMM = 8'h69;
  localparam logic [DATA_W-1:0] OP_SBC_IMM = 8'hE9;
  localparam logic [DATA_W-1:0] OP_AND_IMM = 8'h29;
  localparam logic [DATA_W-1:0] OP_ORA_IMM = 8'h09;
  localparam logic [DATA_W-1:0] OP_EOR_IMM = 8'h49;
  localparam logic [DATA_W-1:0] OP_TAX     = 8'hAA;
  localparam logic [DATA_W-1:0] OP_TXA     = 8'h8A;
  localparam logic [DATA_W-1:0] OP_TAY     = 8'hA8;
  localparam logic [DATA_W-1:0] OP_TYA     = 8'h98;
  localparam logic [DATA_W-1:0] OP_INX     = 8'hE8;
  localparam logic [DATA_W-1:0] OP_INY     = 8'hC8;
  localparam logic [DATA_W-1:0] OP_DEX     = 8'hCA;
  localparam logic [DATA_W-1:0] OP_DEY     = 8'h88;
  localparam logic [DATA_W-1:0] OP_NOP     = 8'hEA;
  localparam logic [DATA_W-1:0] OP_JMP_ABS = 8'h4C;

  typedef enum logic [1:0] {
    CLS_OPERAND = 2'd0,
    CLS_EXEC    = 2'd1,
    CLS_JMP     = 2'd2,
    CLS_ILLEGAL = 2'd3
  } op_class_e;

  typedef enum logic [1:0] {
    DST_NONE = 2'd0,
    DST_A    = 2'd1,
    DST_X    = 2'd2,
    DST_Y    = 2'd3
  } dest_e;

  typedef struct packed {
    op_class_e             cls;
    dest_e                 dest;
    logic [ALU_OP_W-1:0]   alu_op;
    logic [SEL_W-1:0]      a_sel;
    logic [SEL_W-1:0]      b_sel;
    logic                  arith;   // ADC/SBC: consume carry, update C/V
  } dec_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/cpu_opcode_decode.sv
// Combinational opcode decoder: instruction register to class, destination and ALU setup.
module cpu_opcode_decode
  import cpu_pkg::*;
(
  input  logic [DATA_W-1:0] ir_i,
  output dec_t              dec_o
);

  always_comb begin
    dec_o.cls    = CLS_ILLEGAL;
    dec_o.dest   = DST_NONE;
    dec_o.alu_op = ALU_OR;
    dec_o.a_sel  = ASEL_ZERO;
    dec_o.b_sel  = BSEL_MEM;
    dec_o.arith  = 1'b0;
    case (ir_i)
      OP_LDA_IMM: begin dec_o.cls = CLS_OPERAND; dec_o.dest = DST_A; end
      OP_LDX_IMM: begin dec_o.cls = CLS_OPERAND; dec_o.dest = DST_X; end
      OP_LDY_IMM: begin dec_o.cls = CLS_OPERAND; dec_o.dest = DST_Y; end
      OP_ADC_IMM: begin
        dec_o.cls = CLS_OPERAND; dec_o.dest = DST_A; dec_o.alu_op = ALU_ADD;
        dec_o.a_sel = ASEL_A; dec_o.arith = 1'b1;
      end
      OP_SBC_IMM: begin
        dec_o.cls = CLS_OPERAND; dec_o.dest = DST_A; dec_o.alu_op = ALU_SUB;
        dec_o.a_sel = ASEL_A; dec_o.arith = 1'b1;
      end
      OP_AND_IMM: begin
        dec_o.cls = CLS_OPERAND; dec_o.dest = DST_A; dec_o.alu_op = ALU_AND; dec_o.a_sel = ASEL_A;
      end
      OP_ORA_IMM: begin
        dec_o.cls = CLS_OPERAND; dec_o.dest = DST_A; dec_o.alu_op = ALU_OR; dec_o.a_sel = ASEL_A;
      end
      OP_EOR_IMM: begin
        dec_o.cls = CLS_OPERAND; dec_o.dest = DST_A; dec_o.alu_op = ALU_XOR; dec_o.a_sel = ASEL_A;
      end
      // Transfers pass the source through OR with zero so N/Z follow the moved value
      OP_TAX: begin dec_o.cls = CLS_EXEC; dec_o.dest = DST_X; dec_o.b_sel = BSEL_A; end
      OP_TXA: begin dec_o.cls = CLS_EXEC; dec_o.dest = DST_A; dec_o.b_sel = BSEL_X; end
      OP_TAY: begin dec_o.cls = CLS_EXEC; dec_o.dest = DST_Y; dec_o.b_sel = BSEL_A; end
      OP_TYA: begin dec_o.cls = CLS_EXEC; dec_o.dest = DST_A; dec_o.b_sel = BSEL_Y; end
      OP_INX: begin
        dec_o.cls = CLS_EXEC; dec_o.dest = DST_X; dec_o.alu_op = ALU_INC; dec_o.a_sel = ASEL_X;
      end
      OP_INY: begin
        dec_o.cls = CLS_EXEC; dec_o.dest = DST_Y; dec_o.alu_op = ALU_INC; dec_o.a_sel = ASEL_Y;
      end
      OP_DEX: begin
        dec_o.cls = CLS_EXEC; dec_o.dest = DST_X; dec_o.alu_op = ALU_DEC; dec_o.a_sel = ASEL_X;
      end
      OP_DEY: begin
        dec_o.cls = CLS_EXEC; dec_o.dest = DST_Y; dec_o.alu_op = ALU_DEC; dec_o.a_sel = ASEL_Y;
      end
      OP_NOP:     dec_o.cls = CLS_EXEC;
      OP_JMP_ABS: dec_o.cls = CLS_JMP;
      default:    dec_o.cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/cpu_control.sv
// Multi-cycle control FSM for the 8-bit CPU: fetch/decode/execute sequencing and status flags.
module cpu_control
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  output logic                mem_read,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_data_in,
  input  logic                alu_zero,
  input  logic                alu_negative,
  input  logic                alu_carry_out,
  input  logic                alu_overflow,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_carry_in,
  output logic [SEL_W-1:0]    alu_a_sel,
  output logic [SEL_W-1:0]    alu_b_sel,
  output logic [SRC_W-1:0]    reg_src_sel,
  output logic                reg_a_write,
  output logic                reg_x_write,
  output logic                reg_y_write,
  output logic                reg_sp_write,
  output logic                reg_pc_write,
  output logic                pc_increment,
  output logic                sp_push,
  output logic                sp_pop,
  output logic [ADDR_W-1:0]   pc_branch_target,
  output logic                flag_n,
  output logic                flag_z,
  output logic                flag_c,
  output logic                flag_v,
  output logic                halted,
  output logic                instr_done
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  flags_t              flags_q, flags_d;
  logic                halted_q;
  logic                dest_wr;
  dec_t                dec;

  cpu_opcode_decode u_decode (
    .ir_i  (ir_q),
    .dec_o (dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RESET;
      ir_q     <= OP_NOP;
      lo_q     <= '0;
      flags_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      lo_q     <= lo_d;
      flags_q  <= flags_d;
      halted_q <= (state_d == ST_HALT);
    end
  end

  // Strobes respond to mem_ready in the same cycle, so they decode from state and inputs
  always_comb begin
    state_d          = state_q;
    ir_d             = ir_q;
    lo_d             = lo_q;
    flags_d          = flags_q;
    dest_wr          = 1'b0;
    mem_read         = 1'b0;
    alu_op           = ALU_ADD;
    alu_carry_in     = 1'b0;
    alu_a_sel        = ASEL_A;
    alu_b_sel        = BSEL_MEM;
    reg_src_sel      = SRC_ALU;
    reg_pc_write     = 1'b0;
    pc_increment     = 1'b0;
    pc_branch_target = '0;
    instr_done       = 1'b0;

    case (state_q)
      ST_RESET: state_d = ST_FETCH;
      ST_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_d         = mem_data_in;
          pc_increment = 1'b1;
          state_d      = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (dec.cls)
          CLS_OPERAND: state_d = ST_OPERAND;
          CLS_EXEC:    state_d = ST_EXEC;
          CLS_JMP:     state_d = ST_JMP_LO;
          default:     state_d = ST_HALT;
        endcase
      end
      ST_OPERAND: begin
        mem_read     = 1'b1;
        alu_op       = dec.alu_op;
        alu_a_sel    = dec.a_sel;
        alu_b_sel    = dec.b_sel;
        alu_carry_in = dec.arith & flags_q.c;
        if (mem_ready) begin
          dest_wr      = 1'b1;
          pc_increment = 1'b1;
          instr_done   = 1'b1;
          flags_d.n    = alu_negative;
          flags_d.z    = alu_zero;
          if (dec.arith) begin
            flags_d.c = alu_carry_out;
            flags_d.v = alu_overflow;
          end
          state_d = ST_FETCH;
        end
      end
      ST_EXEC: begin
        alu_op     = dec.alu_op;
        alu_a_sel  = dec.a_sel;
        alu_b_sel  = dec.b_sel;
        dest_wr    = 1'b1;
        instr_done = 1'b1;
        if (dec.dest != DST_NONE) begin
          flags_d.n = alu_negative;
          flags_d.z = alu_zero;
        end
        state_d = ST_FETCH;
      end
      ST_JMP_LO: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          lo_d         = mem_data_in;
          pc_increment = 1'b1;
          state_d      = ST_JMP_HI;
        end
      end
      ST_JMP_HI: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          pc_branch_target = {mem_data_in, lo_q};
          reg_pc_write     = 1'b1;
          instr_done       = 1'b1;
          state_d          = ST_FETCH;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RESET;
    endcase

    reg_a_write = dest_wr && (dec.dest == DST_A);
    reg_x_write = dest_wr && (dec.dest == DST_X);
    reg_y_write = dest_wr && (dec.dest == DST_Y);
  end

  assign reg_sp_write = 1'b0;
  assign sp_push      = 1'b0;
  assign sp_pop       = 1'b0;
  assign flag_n       = flags_q.n;
  assign flag_z       = flags_q.z;
  assign flag_c       = flags_q.c;
  assign flag_v       = flags_q.v;
  assign halted       = halted_q;

endmodule
